// File: rtl/count_game_ctrl_if.sv
// Front-end and display bus of the switch-counting game controller.
// When COUNT_GAME_LIVES_EN is defined, the bus also carries the lives_left output.
interface count_game_ctrl_if #(
    parameter int SW_W = 7
);
    logic            en;
    logic            start_p;
    logic            sure_p;
    logic [SW_W-1:0] sw;
    logic [2:0]      state;
    logic [2:0]      round;
    logic [SW_W-1:0] target;
    logic [7:0]      time_left;
    logic [7:0]      err_cnt;
    logic            beep;
`ifdef COUNT_GAME_LIVES_EN
    logic [3:0]      lives_left;
`endif

    modport master (
        output en, start_p, sure_p, sw,
        input  state, round, target, time_left, err_cnt, beep
`ifdef COUNT_GAME_LIVES_EN
        , input lives_left
`endif
    );

    modport slave (
        input  en, start_p, sure_p, sw,
        output state, round, target, time_left, err_cnt, beep
`ifdef COUNT_GAME_LIVES_EN
        , output lives_left
`endif
    );
endinterface

// File: rtl/count_game_ctrl.sv
// Round-based controller for the switch-counting game, with a countdown timer, a buzzer and an LFSR target.
// Defining COUNT_GAME_LIVES_EN adds a LIVES parameter: wrong confirms then use up lives and can end the game.
module count_game_ctrl #(
    parameter int SW_W       = 7,
    parameter int ROUNDS     = 3,
    parameter int TICK_DIV   = 1000000,
    parameter int TIME_LIMIT = 30,
    parameter int BEEP_CYC   = 200000
`ifdef COUNT_GAME_LIVES_EN
    , parameter int LIVES    = 3
`endif
) (
    input logic              clk,
    input logic              rst,
    count_game_ctrl_if.slave bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GREET = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_WIN   = 3'd3;
    localparam logic [2:0] ST_LOSE  = 3'd4;

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BEEP_W  = $clog2(BEEP_CYC + 1);

    logic [2:0]         state_q;
    logic [2:0]         round_q;
    logic [SW_W-1:0]    target_q;
    logic [7:0]         time_q;
    logic [7:0]         err_q;
    logic [BEEP_W-1:0]  beep_cnt;
    logic [PRESC_W-1:0] presc;
    logic [15:0]        lfsr;
    logic               lfsr_fb;
    logic               tick;
    logic               correct;
    logic [SW_W-1:0]    lfsr_pick;
    logic [SW_W-1:0]    next_target;
`ifdef COUNT_GAME_LIVES_EN
    logic [3:0]         lives_q;
`endif

    assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign lfsr_pick   = lfsr[SW_W-1:0];
    // A zero target would be trivially answered with all switches off.
    assign next_target = (lfsr_pick == '0) ? SW_W'(1) : lfsr_pick;
    assign tick        = (state_q == ST_PLAY) && (presc == PRESC_W'(TICK_DIV - 1));
    assign correct     = (bus.sw == target_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            round_q  <= '0;
            target_q <= '0;
            time_q   <= '0;
            err_q    <= '0;
            beep_cnt <= '0;
            presc    <= '0;
            lfsr     <= 16'hACE1;
`ifdef COUNT_GAME_LIVES_EN
            lives_q  <= '0;
`endif
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            if (beep_cnt != '0)
                beep_cnt <= beep_cnt - BEEP_W'(1);
            if (state_q == ST_PLAY)
                presc <= tick ? '0 : presc + PRESC_W'(1);

            if (!bus.en) begin
                state_q  <= ST_IDLE;
                round_q  <= '0;
                target_q <= '0;
                time_q   <= '0;
                err_q    <= '0;
                beep_cnt <= '0;
`ifdef COUNT_GAME_LIVES_EN
                lives_q  <= '0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_GREET;
                    ST_GREET, ST_WIN, ST_LOSE: begin
                        if (bus.start_p) begin
                            state_q  <= ST_PLAY;
                            round_q  <= '0;
                            err_q    <= '0;
                            target_q <= next_target;
                            time_q   <= 8'(TIME_LIMIT);
                            presc    <= '0;
`ifdef COUNT_GAME_LIVES_EN
                            lives_q  <= 4'(LIVES);
`endif
                        end
                    end
                    ST_PLAY: begin
                        // A correct confirm beats a same-cycle tick; a wrong one lets the tick through.
                        if (bus.sure_p && correct) begin
                            if (round_q == 3'(ROUNDS - 1)) begin
                                state_q  <= ST_WIN;
                                beep_cnt <= BEEP_W'(BEEP_CYC);
                            end else begin
                                round_q  <= round_q + 3'd1;
                                target_q <= next_target;
                                time_q   <= 8'(TIME_LIMIT);
                                presc    <= '0;
                            end
                        end else begin
                            if (bus.sure_p) begin
                                if (err_q != 8'hFF)
                                    err_q <= err_q + 8'd1;
                                beep_cnt <= BEEP_W'(BEEP_CYC);
`ifdef COUNT_GAME_LIVES_EN
                                if (lives_q != '0)
                                    lives_q <= lives_q - 4'd1;
                                if (lives_q <= 4'd1)
                                    state_q <= ST_LOSE;
`endif
                            end
                            if (tick) begin
                                time_q <= time_q - 8'd1;
                                if (time_q == 8'd1)
                                    state_q <= ST_LOSE;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.state      = state_q;
    assign bus.round      = round_q;
    assign bus.target     = target_q;
    assign bus.time_left  = time_q;
    assign bus.err_cnt    = err_q;
    assign bus.beep       = (beep_cnt != '0);
`ifdef COUNT_GAME_LIVES_EN
    assign bus.lives_left = lives_q;
`endif
endmodule

// File: tb/tb_count_game_ctrl.sv
// Scoreboard bench for count_game_ctrl: expectations are queued as stimulus is driven and checked one step later.
// Also covers the lives variant when COUNT_GAME_LIVES_EN is defined (LIVES=2).
module tb_count_game_ctrl;
    localparam int SW_W       = 7;
    localparam int ROUNDS     = 3;
    localparam int TICK_DIV   = 4;
    localparam int TIME_LIMIT = 3;
    localparam int BEEP_CYC   = 5;

    localparam int F_STATE  = 0;
    localparam int F_ROUND  = 1;
    localparam int F_TARGET = 2;
    localparam int F_TIME   = 3;
    localparam int F_ERR    = 4;
    localparam int F_BEEP   = 5;
    localparam int F_TNZ    = 6;
    localparam int F_LIVES  = 7;

    typedef struct {
        string tag;
        int    field;
        int    value;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    int              tests_run    = 0;
    int              tests_failed = 0;
    exp_t            exp_q[$];
    logic [15:0]     m_lfsr;
    logic [SW_W-1:0] cur_target;

    count_game_ctrl_if #(.SW_W(SW_W)) bus ();

    count_game_ctrl #(
        .SW_W       (SW_W),
        .ROUNDS     (ROUNDS),
        .TICK_DIV   (TICK_DIV),
        .TIME_LIMIT (TIME_LIMIT),
        .BEEP_CYC   (BEEP_CYC)
`ifdef COUNT_GAME_LIVES_EN
        , .LIVES    (2)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference LFSR, free-running from reset like the one in the controller.
    always @(posedge clk or negedge rst) begin
        if (!rst)
            m_lfsr <= 16'hACE1;
        else
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [SW_W-1:0] model_target();
        logic [SW_W-1:0] v;
        v = m_lfsr[SW_W-1:0];
        return (v == '0) ? SW_W'(1) : v;
    endfunction

    function automatic int observe(input int f);
        case (f)
            F_STATE:  return int'(bus.state);
            F_ROUND:  return int'(bus.round);
            F_TARGET: return int'(bus.target);
            F_TIME:   return int'(bus.time_left);
            F_ERR:    return int'(bus.err_cnt);
            F_BEEP:   return int'(bus.beep);
            F_TNZ:    return (bus.target != '0) ? 1 : 0;
`ifdef COUNT_GAME_LIVES_EN
            F_LIVES:  return int'(bus.lives_left);
`endif
            default:  return -1;
        endcase
    endfunction

    task automatic check_output(input string tag, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic void exp_push(input string tag, input int field, input int value);
        exp_t e;
        e.tag   = tag;
        e.field = field;
        e.value = value;
        exp_q.push_back(e);
    endfunction

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output(e.tag, observe(e.field), e.value);
        end
    endtask

    task automatic push_all_zero(input string tag);
        exp_push({tag, "_state"},  F_STATE,  0);
        exp_push({tag, "_round"},  F_ROUND,  0);
        exp_push({tag, "_target"}, F_TARGET, 0);
        exp_push({tag, "_time"},   F_TIME,   0);
        exp_push({tag, "_err"},    F_ERR,    0);
        exp_push({tag, "_beep"},   F_BEEP,   0);
`ifdef COUNT_GAME_LIVES_EN
        exp_push({tag, "_lives"},  F_LIVES,  0);
`endif
    endtask

    // Called on a falling edge; expectations queued beforehand are checked just after the next rising edge.
    task automatic apply_stimulus(input logic e, input logic s, input logic c, input logic [SW_W-1:0] w);
        bus.en      = e;
        bus.start_p = s;
        bus.sure_p  = c;
        bus.sw      = w;
        @(posedge clk);
        #1;
        drain();
        @(negedge clk);
    endtask

    task automatic enter_play();
        cur_target = model_target();
        exp_push("entry_state",  F_STATE,  2);
        exp_push("entry_round",  F_ROUND,  0);
        exp_push("entry_err",    F_ERR,    0);
        exp_push("entry_time",   F_TIME,   TIME_LIMIT);
        exp_push("entry_target", F_TARGET, int'(cur_target));
        exp_push("entry_tnz",    F_TNZ,    1);
`ifdef COUNT_GAME_LIVES_EN
        exp_push("entry_lives",  F_LIVES,  2);
`endif
        apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic begin_game();
        exp_push("idle_state", F_STATE, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        exp_push("greet_state", F_STATE, 1);
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        enter_play();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [SW_W-1:0] answer;
        int              tl;

        rst         = 1'b0;
        bus.en      = 1'b0;
        bus.start_p = 1'b0;
        bus.sure_p  = 1'b0;
        bus.sw      = '0;
        #2;
        push_all_zero("reset");
        drain();
        @(negedge clk);
        rst = 1'b1;

        // Reset and enable handling
        exp_push("en_greet", F_STATE, 1);
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        enter_play();
        rst = 1'b0;
        #1;
        push_all_zero("async_rst");
        drain();
        @(negedge clk);
        rst = 1'b1;
        exp_push("rst_en_greet", F_STATE, 1);
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        enter_play();
        push_all_zero("en_drop");
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);

        // Full win over three rounds
        begin_game();
        for (int r = 0; r < ROUNDS; r++) begin
            answer = cur_target;
            if (r < ROUNDS - 1) begin
                cur_target = model_target();
                exp_push("win_state",  F_STATE,  2);
                exp_push("win_round",  F_ROUND,  r + 1);
                exp_push("win_time",   F_TIME,   TIME_LIMIT);
                exp_push("win_target", F_TARGET, int'(cur_target));
                exp_push("win_tnz",    F_TNZ,    1);
            end else begin
                exp_push("win_final_state", F_STATE, 3);
                exp_push("win_final_round", F_ROUND, ROUNDS - 1);
                exp_push("win_beep_on",     F_BEEP,  1);
            end
            apply_stimulus(1'b1, 1'b0, 1'b1, answer);
        end
        for (int k = 1; k <= BEEP_CYC; k++) begin
            exp_push("win_beep", F_BEEP, (k < BEEP_CYC) ? 1 : 0);
            exp_push("win_hold", F_STATE, 3);
            apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        end

        // Timeout from a restart out of WIN
        enter_play();
        for (int k = 1; k <= 3 * TICK_DIV; k++) begin
            tl = (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0;
            exp_push("timeout_time",  F_TIME,  tl);
            exp_push("timeout_state", F_STATE, (k == 12) ? 4 : 2);
            apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        end

        // Wrong answers with beep retrigger
        enter_play();
        exp_push("wrong1_err",   F_ERR,   1);
        exp_push("wrong1_state", F_STATE, 2);
        exp_push("wrong1_beep",  F_BEEP,  1);
        apply_stimulus(1'b1, 1'b0, 1'b1, cur_target ^ SW_W'(1));
        exp_push("wrong_gap_beep", F_BEEP, 1);
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        exp_push("wrong2_err",  F_ERR,  2);
        exp_push("wrong2_beep", F_BEEP, 1);
`ifdef COUNT_GAME_LIVES_EN
        exp_push("wrong2_state", F_STATE, 4);
        exp_push("wrong2_lives", F_LIVES, 0);
`else
        exp_push("wrong2_state", F_STATE, 2);
`endif
        apply_stimulus(1'b1, 1'b0, 1'b1, cur_target ^ SW_W'(1));
        for (int k = 1; k <= BEEP_CYC; k++) begin
            exp_push("retrig_beep", F_BEEP, (k < BEEP_CYC) ? 1 : 0);
            apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        end

        // Confirm landing on the final tick of a round
        begin_game();
        for (int k = 1; k < 12; k++) begin
            if (k == 11)
                exp_push("coll_pre_time", F_TIME, 1);
            apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        end
        answer     = cur_target;
        cur_target = model_target();
        exp_push("coll_ok_state",  F_STATE,  2);
        exp_push("coll_ok_round",  F_ROUND,  1);
        exp_push("coll_ok_time",   F_TIME,   TIME_LIMIT);
        exp_push("coll_ok_target", F_TARGET, int'(cur_target));
        apply_stimulus(1'b1, 1'b0, 1'b1, answer);
        for (int k = 13; k < 24; k++) begin
            if (k == 23)
                exp_push("coll_pre2_time", F_TIME, 1);
            apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        end
        exp_push("coll_bad_state", F_STATE, 4);
        exp_push("coll_bad_err",   F_ERR,   1);
        exp_push("coll_bad_time",  F_TIME,  0);
`ifdef COUNT_GAME_LIVES_EN
        exp_push("coll_bad_lives", F_LIVES, 1);
`endif
        apply_stimulus(1'b1, 1'b0, 1'b1, cur_target ^ SW_W'(1));

        // Restart from LOSE, then a stray start pulse inside PLAY
        enter_play();
        exp_push("play_start_state", F_STATE, 2);
        exp_push("play_start_round", F_ROUND, 0);
        exp_push("play_start_time",  F_TIME,  TIME_LIMIT);
        apply_stimulus(1'b1, 1'b1, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
